// File: rtl/mdu_iterative.sv
// Radix-2 iterative multiply/divide unit with HI/LO state for the EX stage.
// Optional MDU_EARLY_OUT_EN: multiplies finish as soon as the remaining multiplier is zero.
module mdu_iterative #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             flush_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             dbz_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q, neg_res_q, neg_rem_q, dbz_q, done_q, dbz_out_q;
  logic [WIDTH-1:0]   hi_q, lo_q, mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, mcand_q, mcand_d, prod_fix;

  logic               accept, op_signed, rs_neg, rt_neg, div_zero, last_iter, early_out;
  logic [WIDTH-1:0]   rs_mag, rt_mag, div_sub, quot_fix, rem_fix, hi_d, lo_d;
  logic [WIDTH:0]     div_r;
  logic               div_ge;

  assign accept    = (state_q == IDLE) && start_i && !flush_i;
  assign op_signed = ~op_i[0];
  assign rs_neg    = op_signed & rs_data_i[WIDTH-1];
  assign rt_neg    = op_signed & rt_data_i[WIDTH-1];
  // Negating the most-negative value wraps to itself, which read unsigned is 2^(WIDTH-1).
  assign rs_mag    = rs_neg ? -rs_data_i : rs_data_i;
  assign rt_mag    = rt_neg ? -rt_data_i : rt_data_i;
  assign div_zero  = op_i[1] && (rt_data_i == '0);

  // Divide: upper half of prod_q is the partial remainder, lower half shifts dividend out and quotient in.
  assign div_r   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_ge  = div_r >= {1'b0, mcand_q[WIDTH-1:0]};
  assign div_sub = div_r[WIDTH-1:0] - mcand_q[WIDTH-1:0];

`ifdef MDU_EARLY_OUT_EN
  assign early_out = !is_div_q && (mplier_q[WIDTH-1:1] == '0);
`else
  assign early_out = 1'b0;
`endif
  assign last_iter = (cnt_q == '0) || early_out;

  always_comb begin
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (accept) begin
      mplier_d = rt_mag;
      if (div_zero) begin
        prod_d  = {rs_data_i, {WIDTH{1'b0}}};
        mcand_d = '0;
      end else if (op_i[1]) begin
        prod_d  = {{WIDTH{1'b0}}, rs_mag};
        mcand_d = {{WIDTH{1'b0}}, rt_mag};
      end else begin
        prod_d  = '0;
        mcand_d = {{WIDTH{1'b0}}, rs_mag};
      end
    end else if (state_q == CALC) begin
      if (is_div_q) begin
        prod_d = {(div_ge ? div_sub : div_r[WIDTH-1:0]), prod_q[WIDTH-2:0], div_ge};
      end else begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
    end
  end

  always_comb begin
    prod_fix = neg_res_q ? -prod_q : prod_q;
    quot_fix = neg_res_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
    if (dbz_q) begin
      hi_d = prod_q[2*WIDTH-1:WIDTH];
      lo_d = '1;
    end else if (is_div_q) begin
      hi_d = rem_fix;
      lo_d = quot_fix;
    end else begin
      hi_d = prod_fix[2*WIDTH-1:WIDTH];
      lo_d = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    prod_q   <= prod_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_we_i) hi_q <= wdata_i;
          if (lo_we_i) lo_q <= wdata_i;
          if (accept) begin
            is_div_q  <= op_i[1];
            neg_res_q <= rs_neg ^ rt_neg;
            neg_rem_q <= rs_neg;
            dbz_q     <= div_zero;
            cnt_q     <= CNT_W'(WIDTH - 1);
            state_q   <= div_zero ? FIX : CALC;
          end
        end
        CALC: begin
          if (flush_i)        state_q <= IDLE;
          else if (last_iter) state_q <= FIX;
          else                cnt_q   <= cnt_q - 1'b1;
        end
        FIX: begin
          state_q <= IDLE;
          if (!flush_i) begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= 1'b1;
            dbz_out_q <= dbz_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign dbz_o  = dbz_out_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Parametrised multi-cycle multiply/divide unit for the next-generation pipelined CPU. It adds MULT/MULTU/DIV/DIVU and HI/LO state to the EX stage.
- Radix-2 iterative datapath: one bit per cycle, operating on magnitudes, with a final sign-fix cycle.
- The hazard unit uses busy_o to hold PC and IF/ID and to bubble ID/EX until done_o.

Parameters:
- WIDTH, 32, operand width in bits. HI and LO are each WIDTH bits. Legal values are 8..64.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  operation request from EX; sampled only in IDLE
- op_i  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i
- rs_data_i  in  WIDTH  multiplicand / dividend
- rt_data_i  in  WIDTH  multiplier / divisor
- flush_i  in  1  abort the in-flight operation (branch/jump flush of EX)
- hi_we_i  in  1  MTHI write
- lo_we_i  in  1  MTLO write
- wdata_i  in  WIDTH  MTHI/MTLO data
- busy_o  out  1  operation in progress (state != IDLE)
- done_o  out  1  one-cycle pulse; HI/LO hold the new result
- dbz_o  out  1  one-cycle pulse together with done_o when a divide had a zero divisor
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE; hi_o=0, lo_o=0; busy_o=0, done_o=0, dbz_o=0; counter=0. Reset mid-operation discards it.
- States: IDLE, CALC, FIX.
- IDLE:
  - start_i=1 and flush_i=0 at edge E0: latch op, operand magnitudes and sign flags.
  - Signed ops take |x|; the magnitude of the most-negative value is 2^(WIDTH-1) unsigned.
  - Next state is CALC with counter=WIDTH-1.
  - Exception: divide with rt_data_i==0 goes directly to FIX and is flagged div-by-zero.
- CALC, one bit per edge:
  - Multiply: shift-add, LSB-first; the multiplier register shifts right.
  - Divide: restoring shift-subtract.
  - When counter==0 at an edge, go to FIX. The counter decrements otherwise.
  - CALC occupies edges E1..E(WIDTH).
- FIX (edge E(WIDTH+1)):
  - Apply signs. Product is negated if the signs differ. Quotient is negated if the signs differ. Remainder takes the dividend's sign.
  - Write HI = product[2W-1:W] or remainder; LO = product[W-1:0] or quotient.
  - Register done_o=1 for exactly one cycle, then return to IDLE.
  - Total latency: done_o is high in the cycle after E(WIDTH+1), i.e. WIDTH+1 edges after start.
- Divide by zero: FIX at E1 writes HI=rs_data (as latched), LO=all ones; done_o=1 and dbz_o=1 for one cycle.
- Overflow case: signed MIN/-1 gives LO=MIN, HI=0, with no flag.
- busy_o is combinational from state: high from after E0 until FIX completes. It is low in the done_o cycle.
- start_i while busy is ignored (no queueing).
- flush_i while in CALC or FIX: return to IDLE at the next edge. HI/LO are unchanged and done_o is not pulsed.
- flush_i and start_i together in IDLE: flush wins and start is dropped.
- hi_we_i / lo_we_i:
  - Honoured only in IDLE; they write HI/LO at the edge.
  - Ignored while busy.
  - In IDLE together with start_i: the write applies and start is accepted; the later result overwrites.
- A FIX write has priority over MTHI/MTLO; the latter cannot coexist with it since FIX only occurs while busy.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined: a multiply in CALC goes to FIX at any edge where the shifted multiplier becomes zero, giving variable latency. Divides are unchanged.
- Undefined: multiply always runs WIDTH CALC cycles, giving fixed latency of WIDTH+1.

Test Plan:
- WIDTH=32, MULT rs=0xFFFFFFFD (-3), rt=7 -> done_o after E33; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy_o high for 33 cycles.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0, dbz_o=0.
- DIVU rs=0xA, rt=0 -> done_o and dbz_o pulse after E1; HI=0x0000000A, LO=0xFFFFFFFF.
- MULTU 3*5 started, flush_i at E10 -> IDLE at E11; HI/LO keep prior values (e.g. from MTLO 0x1234: LO=0x1234); no done_o. A start_i during busy is ignored.
- Reset sequencing:
  - rst_i low mid-CALC -> hi_o/lo_o/busy_o immediately 0.
  - After release, MTHI 0xDEAD in IDLE -> hi_o=0xDEAD next cycle.
  - MTHI while busy -> no change.
- With MDU_EARLY_OUT_EN: MULTU rs=3, rt=5 -> FIX at E4; done_o after E4; LO=15, HI=0. Without the macro: done_o after E33, same result.
